branch_redirect_ctrl: RTL and testbench

- Sequences the control-flow redirect produced by the EX-stage branch resolution logic.
- Captures a resolved taken branch, JAL or JALR target and presents one registered redirect to the PC register.
- Drives flushes of the wrong-path IF/ID and ID/EX registers for a fixed number of cycles.
- Holds a pending redirect across pipeline stalls; sits between the branch/ALU result path and the PC/pipeline-register enables.

---
 rtl/branch_redirect_pkg.sv | 32 +++
 rtl/redirect_perf_cnt.sv | 22 ++
 rtl/branch_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_pkg.sv
// Shared types for the EX-stage redirect controller: FSM states, redirect causes
// and the cause decode used when masking a captured target.
package branch_redirect_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      HOLD     = 2'd2,
      FLUSH    = 2'd3
   } redirect_state_e;

   typedef enum logic [1:0] {
      CAUSE_BR   = 2'd0,
      CAUSE_JAL  = 2'd1,
      CAUSE_JALR = 2'd2
   } redirect_cause_e;

   localparam int FLUSH_CYCLES_MAX = 15;

   // JALR wins over JAL, which wins over a taken conditional branch.
   function automatic redirect_cause_e decode_cause(input logic jal, input logic jalr);
      redirect_cause_e cause;
      cause = CAUSE_BR;
      if (jalr) begin
         cause = CAUSE_JALR;
      end else if (jal) begin
         cause = CAUSE_JAL;
      end
      return cause;
   endfunction

endpackage

// File: rtl/redirect_perf_cnt.sv
// 32-bit wrapping event counter with synchronous active-low clear and
// an increment enable.
module redirect_perf_cnt (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        en,
   output logic [31:0] count
);

   logic [31:0] count_reg;

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 32'd1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Captures a resolved EX-stage control transfer, presents one registered redirect
// to the PC and flushes wrong-path stages. Perf counters: BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl
   import branch_redirect_pkg::*;
#(
   parameter int PC_W         = 9,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic            ex_br_taken,
   input  logic            ex_jal,
   input  logic            ex_jalr,
   input  logic [31:0]     ex_target,
   input  logic            stall,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic            busy,
   output logic            tgt_err,
   output logic [31:0]     perf_redirects,
   output logic [31:0]     perf_flush_cyc
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   redirect_state_e state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [PC_W-1:0]  target_reg;
   logic             err_reg;
   logic             trigger;
   logic             capture;
   logic [31:0]      tgt_masked;
   logic             tgt_bad;

   assign trigger = ex_valid & (ex_br_taken | ex_jal | ex_jalr);

   always_comb begin
      tgt_masked = ex_target;
      if (decode_cause(ex_jal, ex_jalr) == CAUSE_JALR) begin
         tgt_masked[0] = 1'b0;
      end
      // Out-of-range targets still redirect with the truncated value.
      tgt_bad = tgt_masked[1] | ((tgt_masked >> PC_W) != 32'd0);
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger) begin
               capture    = 1'b1;
               state_next = REDIRECT;
            end
         end
         REDIRECT, HOLD: begin
            if (stall) begin
               state_next = HOLD;
            end else begin
               cnt_next   = CNT_LOAD;
               state_next = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            // The accepted redirect cycle was the first flush cycle, so the
            // counter reaches zero as the FSM re-enters IDLE.
            if (!stall) begin
               cnt_next = cnt_reg - CNT_ONE;
               if (cnt_reg <= CNT_ONE) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         target_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (capture) begin
            target_reg <= tgt_masked[PC_W-1:0];
            err_reg    <= err_reg | tgt_bad;
         end
      end
   end

   assign redirect_valid = (state_reg == REDIRECT) || (state_reg == HOLD);
   assign redirect_pc    = target_reg;
   assign flush_if_id    = (state_reg != IDLE);
   assign flush_id_ex    = (state_reg != IDLE);
   assign busy           = (state_reg != IDLE);
   assign tgt_err        = err_reg;

`ifdef BRANCH_REDIRECT_PERF_EN
   logic redirect_accept;
   assign redirect_accept = redirect_valid & ~stall;

   redirect_perf_cnt u_perf_redirects (
      .clk     (clk),
      .clear_n (reset),
      .en      (redirect_accept),
      .count   (perf_redirects)
   );

   redirect_perf_cnt u_perf_flush_cyc (
      .clk     (clk),
      .clear_n (reset),
      .en      (flush_id_ex & ~stall),
      .count   (perf_flush_cyc)
   );
`else
   assign perf_redirects = 32'b0;
   assign perf_flush_cyc = 32'b0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations.
// Perf checks are compiled only when BRANCH_REDIRECT_PERF_EN is defined.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_br_taken, ex_jal, ex_jalr;
   logic [31:0] ex_target;
   logic        stall;
   logic        redirect_valid;
   logic [8:0]  redirect_pc;
   logic        flush_if_id, flush_id_ex, busy, tgt_err;
   logic [31:0] perf_redirects, perf_flush_cyc;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.PC_W(9), .FLUSH_CYCLES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_valid       (ex_valid),
      .ex_br_taken    (ex_br_taken),
      .ex_jal         (ex_jal),
      .ex_jalr        (ex_jalr),
      .ex_target      (ex_target),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .busy           (busy),
      .tgt_err        (tgt_err),
      .perf_redirects (perf_redirects),
      .perf_flush_cyc (perf_flush_cyc)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Advance one edge; sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic jal, input logic jalr, input logic [31:0] tgt);
      ex_valid    = br | jal | jalr;
      ex_br_taken = br;
      ex_jal      = jal;
      ex_jalr     = jalr;
      ex_target   = tgt;
   endtask

   // Check the four control outputs packed as {redirect_valid, flush_if_id, flush_id_ex, busy}.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      check_val(tag, {28'd0, redirect_valid, flush_if_id, flush_id_ex, busy}, {28'd0, exp});
   endtask

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0040);

      // Reset held for 3 cycles while a trigger is present.
      for (int i = 0; i < 3; i++) begin
         step();
         check_ctl($sformatf("rst_ctl_%0d", i), 4'b0000);
         check_val($sformatf("rst_pc_%0d", i), {23'd0, redirect_pc}, 32'd0);
         check_val($sformatf("rst_err_%0d", i), {31'd0, tgt_err}, 32'd0);
      end
      check_val("rst_perf_r", perf_redirects, 32'd0);
      check_val("rst_perf_f", perf_flush_cyc, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      reset = 1'b1;
      step();
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);
      check_val("post_rst_err", {31'd0, tgt_err}, 32'd0);

      // Taken branch: one redirect cycle, two flush cycles, then IDLE.
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0040);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_ctl("br_c1_ctl", 4'b1111);
      check_val("br_c1_pc", {23'd0, redirect_pc}, 32'h040);
      check_val("br_c1_err", {31'd0, tgt_err}, 32'd0);
      step();
      check_ctl("br_c2_ctl", 4'b0111);
      step();
      check_ctl("br_c3_ctl", 4'b0000);

      // JALR clears bit0 of the target.
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0025);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_val("jalr_pc", {23'd0, redirect_pc}, 32'h024);
      check_val("jalr_err", {31'd0, tgt_err}, 32'd0);
      step();
      step();
      check_ctl("jalr_idle", 4'b0000);

      // JAL with bit1 set: error flagged, truncated target still used.
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0206);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_val("jal_pc", {23'd0, redirect_pc}, 32'h006);
      check_val("jal_err", {31'd0, tgt_err}, 32'd1);
      step();
      step();
      check_val("jal_err_sticky", {31'd0, tgt_err}, 32'd1);

      // Mid-operation reset drops the redirect and clears the error.
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0080);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_ctl("mid_pre_ctl", 4'b1111);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_ctl("mid_rst_ctl", 4'b0000);
      check_val("mid_rst_pc", {23'd0, redirect_pc}, 32'd0);
      check_val("mid_rst_err", {31'd0, tgt_err}, 32'd0);
      step();

      // Target above the PC range only: error set, low bits used.
      drive(1'b1, 1'b0, 1'b0, 32'h0000_1040);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_val("range_pc", {23'd0, redirect_pc}, 32'h040);
      check_val("range_err", {31'd0, tgt_err}, 32'd1);
      step();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();

      // Stall held for 3 cycles from the redirect cycle: 4 redirect cycles total.
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0100);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1;
         check_ctl($sformatf("stall_ctl_%0d", i), 4'b1111);
         check_val($sformatf("stall_pc_%0d", i), {23'd0, redirect_pc}, 32'h100);
         step();
      end
      stall = 1'b0;
      check_ctl("stall_rel_ctl", 4'b1111);
      check_val("stall_rel_pc", {23'd0, redirect_pc}, 32'h100);
`ifdef BRANCH_REDIRECT_PERF_EN
      check_val("stall_perf_pre", perf_redirects, 32'd0);
`endif
      step();
      check_ctl("stall_flush_ctl", 4'b0111);
`ifdef BRANCH_REDIRECT_PERF_EN
      check_val("stall_perf_post", perf_redirects, 32'd1);
`endif
      step();
      check_ctl("stall_idle_ctl", 4'b0000);

      // A trigger during FLUSH is wrong-path and must be ignored.
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0010);
      step();
      check_val("wp_pc", {23'd0, redirect_pc}, 32'h010);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      step();
      check_ctl("wp_flush_ctl", 4'b0111);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0088);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_ctl("wp_idle_ctl", 4'b0000);
      step();
      check_ctl("wp_no_pulse", 4'b0000);
      check_val("wp_pc_kept", {23'd0, redirect_pc}, 32'h010);
`ifdef BRANCH_REDIRECT_PERF_EN
      check_val("wp_perf_r", perf_redirects, 32'd2);
      check_val("wp_perf_f", perf_flush_cyc, 32'd4);

      // Counter wrap: preload to all ones, one redirect brings it to zero.
      force dut.u_perf_redirects.count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.u_perf_redirects.count_reg;
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0020);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_val("wrap_pre", perf_redirects, 32'hFFFF_FFFF);
      step();
      check_val("wrap_post", perf_redirects, 32'd0);
      step();
`else
      check_val("perf_r_tied", perf_redirects, 32'd0);
      check_val("perf_f_tied", perf_flush_cyc, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      fail_cnt++;
      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $fatal(1, "timeout");
   end

endmodule
